dbus_sram_responder: RTL and testbench

DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

---
 rtl/dbus_sram_responder.sv | 143 ++++++++++++++
 tb/tb_dbus_sram_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - fixed-latency data-bus SRAM responder with byte-strobe writes
// Optional build macro RESP_MISALIGN_CHECK_EN rejects accesses not aligned to 2^size.
package dbus_pkg;
  typedef logic [2:0] msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       addr_err,
  output logic       busy
);

  localparam int         IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] LOAD = 3'(LATENCY - 1);
`ifdef RESP_MISALIGN_CHECK_EN
  localparam bit CHK_ALIGN = 1'b1;
`else
  localparam bit CHK_ALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [63:0] lat_addr;
  msize_t      lat_size;
  logic [7:0]  lat_strobe;
  logic [63:0] lat_data;
  logic [63:0] rdata;
  logic        data_ok_q;
  logic        err_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          to_resp;
  logic [63:0]   cur_addr;
  msize_t        cur_size;
  logic [63:0]   off;
  logic          in_range;
  logic          misaligned;
  logic          cur_err;
  logic [IW-1:0] cur_idx;

  assign accept = (state == IDLE) && dreq.valid && !reset;

  // While idle the live request is decoded so a LATENCY=1 access can be answered next cycle.
  assign cur_addr   = (state == IDLE) ? dreq.addr : lat_addr;
  assign cur_size   = (state == IDLE) ? dreq.size : lat_size;
  assign off        = cur_addr - BASE_ADDR;
  assign in_range   = (cur_addr >= BASE_ADDR) && ((off >> 3) < 64'(DEPTH_WORDS));
  assign misaligned = (cur_addr & ((64'd1 << cur_size) - 64'd1)) != 64'd0;
  assign cur_err    = !in_range || (CHK_ALIGN && misaligned);
  assign cur_idx    = off[IW+2:3];

  assign to_resp = ((state == IDLE) && dreq.valid && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt <= 3'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      lat_addr   <= 64'd0;
      lat_size   <= 3'd0;
      lat_strobe <= 8'd0;
      lat_data   <= 64'd0;
      rdata      <= 64'd0;
      data_ok_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
      rdata     <= 64'd0;
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            lat_addr   <= dreq.addr;
            lat_size   <= dreq.size;
            lat_strobe <= dreq.strobe;
            lat_data   <= dreq.data;
            cnt        <= LOAD;
            state      <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt <= 3'd1) begin
            cnt   <= 3'd0;
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Read data is captured before the RESP-cycle write, so writes return the old word.
      if (to_resp) begin
        data_ok_q <= 1'b1;
        err_q     <= cur_err;
        rdata     <= cur_err ? 64'd0 : mem[cur_idx];
      end
    end
  end

  // Backing store is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && !err_q && (lat_strobe != 8'd0)) begin
      for (int i = 0; i < 8; i++) begin
        if (lat_strobe[i]) mem[cur_idx][8*i +: 8] <= lat_data[8*i +: 8];
      end
    end
  end

  assign dresp.addr_ok = accept;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = rdata;
  assign addr_err      = err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb/tb_dbus_sram_responder.sv - randomized self-checking bench for dbus_sram_responder
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq, dreq1;
  dbus_resp_t dresp, dresp1;
  logic       addr_err, busy, addr_err1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model [DEPTH];
  bit          known [DEPTH];

  always #5 clk = ~clk;

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .addr_err(addr_err), .busy(busy)
  );

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1), .addr_err(addr_err1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_err(input logic [63:0] a, input logic [2:0] sz);
    bit oor;
    bit mis;
    oor = (a < BASE) || (a >= BASE + 64'(8 * DEPTH));
    mis = (a % (64'd1 << sz)) != 64'd0;
`ifdef RESP_MISALIGN_CHECK_EN
    return oor || mis;
`else
    return oor || (mis && 1'b0);
`endif
  endfunction

  task automatic drive(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                       input logic [63:0] d);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = sz;
    dreq.strobe = st;
    dreq.data   = d;
  endtask

  task automatic xact(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                      input logic [63:0] d, output logic [63:0] got, output logic gerr);
    bit          e;
    bit          kn;
    int          idx;
    logic [63:0] exp;
    e   = model_err(a, sz);
    idx = e ? 0 : int'((a - BASE) / 64'd8);
    exp = e ? 64'd0 : model[idx];
    kn  = e || known[idx];
    got  = 64'd0;
    gerr = 1'b0;
    @(negedge clk);
    drive(a, sz, st, d);
    #1;
    check("addr_ok_accept", 64'(dresp.addr_ok), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
    @(posedge clk);
    if (!e && st != 8'd0) begin
      for (int b = 0; b < 8; b++) if (st[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      if (st == 8'hFF) known[idx] = 1'b1;
    end
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check("data_ok_timing", 64'(dresp.data_ok), 64'(k == LAT));
      check("busy_active", 64'(busy), 64'd1);
      if (k == LAT) begin
        got  = dresp.data;
        gerr = addr_err;
        if (kn) check("rdata", dresp.data, exp);
        check("addr_err", 64'(addr_err), 64'(e));
        dreq.valid = 1'b0;
      end else begin
        check("data_zero_wait", dresp.data, 64'd0);
        check("err_zero_wait", 64'(addr_err), 64'd0);
        drive({$urandom, $urandom}, 3'($urandom), 8'($urandom), {$urandom, $urandom});
        #1;
        check("addr_ok_wait", 64'(dresp.addr_ok), 64'd0);
      end
    end
    @(negedge clk);
    check("data_ok_drop", 64'(dresp.data_ok), 64'd0);
    check("busy_drop", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] g;
    logic        ge;
    logic [63:0] old;
    logic [63:0] v1;

    dreq  = '0;
    dreq1 = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    drive(BASE, 3'd3, 8'h00, 64'd0);
    #1;
    check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst_data", dresp.data, 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    dreq.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      xact(BASE + 64'(8 * i), 3'd3, 8'hFF, {$urandom, $urandom}, g, ge);

    xact(BASE, 3'd3, 8'hFF, 64'h1122334455667788, g, ge);
    xact(BASE, 3'd3, 8'h00, 64'd0, g, ge);
    check("read_word0", g, 64'h1122334455667788);

    xact(BASE + 64'd8, 3'd3, 8'hFF, 64'd0, g, ge);
    xact(BASE + 64'd8, 3'd3, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, g, ge);
    xact(BASE + 64'd8, 3'd3, 8'h00, 64'd0, g, ge);
    check("strobe_merge", g, 64'h00000000_BBBBBBBB);

    xact(64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, g, ge);
    check("oor_data", g, 64'd0);
    check("oor_err", 64'(ge), 64'd1);

    xact(BASE + 64'd2, 3'd2, 8'h0F, 64'hCAFEF00D_12345678, g, ge);
`ifdef RESP_MISALIGN_CHECK_EN
    check("misalign_err", 64'(ge), 64'd1);
`else
    check("misalign_err", 64'(ge), 64'd0);
`endif
    xact(BASE, 3'd3, 8'h00, 64'd0, g, ge);

    old = model[2];
    @(negedge clk);
    drive(BASE + 64'd16, 3'd3, 8'hFF, ~old);
    @(posedge clk);
    @(negedge clk);
    check("wait_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("midrst_data_ok", 64'(dresp.data_ok), 64'd0);
    check("midrst_data", dresp.data, 64'd0);
    check("midrst_err", 64'(addr_err), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    dreq.valid = 1'b0;
    xact(BASE + 64'd16, 3'd3, 8'h00, 64'd0, g, ge);
    check("midrst_no_write", g, old);

    repeat (40) begin
      logic [63:0] a;
      int          sel;
      sel = int'($urandom % 10);
      if (sel == 0) a = BASE - 64'(8 * (1 + $urandom % 4));
      else a = BASE + 64'(8 * ($urandom % (DEPTH + 2))) + (($urandom % 3 == 0) ? 64'($urandom % 8) : 64'd0);
      xact(a, 3'($urandom % 4), ($urandom % 2 == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom}, g, ge);
    end

    v1 = {$urandom, $urandom};
    @(negedge clk);
    dreq1.valid  = 1'b1;
    dreq1.addr   = BASE;
    dreq1.size   = 3'd3;
    dreq1.strobe = 8'hFF;
    dreq1.data   = v1;
    #1;
    check("l1_wr_addr_ok", 64'(dresp1.addr_ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("l1_wr_data_ok", 64'(dresp1.data_ok), 64'd1);
    check("l1_wr_busy", 64'(busy1), 64'd1);
    dreq1.valid = 1'b0;
    @(negedge clk);
    dreq1.valid  = 1'b1;
    dreq1.strobe = 8'h00;
    dreq1.data   = 64'd0;
    #1;
    check("l1_addr_ok_T", 64'(dresp1.addr_ok), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("l1_data_ok", 64'(dresp1.data_ok), 64'(c != 2));
      check("l1_addr_ok", 64'(dresp1.addr_ok), 64'(c == 2));
      check("l1_data", dresp1.data, (c != 2) ? v1 : 64'd0);
      check("l1_addr_err", 64'(addr_err1), 64'd0);
      if (c == 3) dreq1.valid = 1'b0;
    end
    @(negedge clk);
    check("l1_busy_end", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
